// File: rtl/bsg_cache_to_axi_tx_arbiter.sv
// Round-robin arbiter that shares one AXI write (tx) engine between several
// cache DMA write channels. A grant stays locked on its cache until the tx
// engine accepts it, the number of in-flight writes is bounded, and B
// responses are steered back to the issuing cache through an in-order id FIFO.
module bsg_cache_to_axi_tx_arbiter #(
    parameter int num_cache_p       = 2,
    parameter int addr_width_p      = 28,
    parameter int mask_width_p      = 8,
    parameter int max_outstanding_p = 4,
    localparam int lg_cache_lp = (num_cache_p <= 2) ? 1 : $clog2(num_cache_p),
    localparam int lg_out_lp   = $clog2(max_outstanding_p + 1),
    localparam int lg_fifo_lp  = (max_outstanding_p <= 2) ? 1 : $clog2(max_outstanding_p)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_cache_p-1:0]                req_v_i,
    input  logic [num_cache_p*addr_width_p-1:0]   req_addr_i,
    input  logic [num_cache_p*mask_width_p-1:0]   req_mask_i,
    output logic [num_cache_p-1:0]                req_yumi_o,
    output logic                                  tx_v_o,
    output logic [lg_cache_lp-1:0]                tx_cache_id_o,
    output logic [addr_width_p-1:0]               tx_addr_o,
    output logic [mask_width_p-1:0]               tx_mask_o,
    input  logic                                  tx_yumi_i,
    input  logic                                  axi_bvalid_i,
    input  logic [1:0]                            axi_bresp_i,
    output logic [num_cache_p-1:0]                wr_done_o,
    output logic [num_cache_p-1:0]                wr_err_o,
    output logic [lg_out_lp-1:0]                  outstanding_o,
    output logic                                  protocol_err_o
);

    typedef enum logic {IDLE, HELD} state_e;

    state_e                  state_q, state_d;
    logic [lg_cache_lp-1:0]  locked_id_q, locked_id_d;
    logic [lg_cache_lp-1:0]  rr_ptr_q, rr_ptr_d;
    logic [lg_out_lp-1:0]    count_q, count_d;
    logic [lg_fifo_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [lg_fifo_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic                    protocol_err_q, protocol_err_d;
    logic [lg_cache_lp-1:0]  fifo_q [max_outstanding_p];

    logic [lg_cache_lp-1:0]  rr_grant;
    logic                    rr_found;
    logic [lg_cache_lp-1:0]  grant;
    logic                    tx_v;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic [lg_cache_lp-1:0]  head;

    // Cache index modulo the number of caches.
    function automatic logic [lg_cache_lp-1:0] cache_idx(input int v);
        return lg_cache_lp'(v % num_cache_p);
    endfunction

    // FIFO pointer increment that wraps at the FIFO depth (need not be a power of two).
    function automatic logic [lg_fifo_lp-1:0] next_ptr(input logic [lg_fifo_lp-1:0] p);
        return (p == lg_fifo_lp'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (count_q == lg_out_lp'(max_outstanding_p));
    assign head = fifo_q[rd_ptr_q];

    // Round-robin search: first requesting cache at or above rr_ptr, cyclically.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        for (int i = 0; i < num_cache_p; i++) begin
            if (!rr_found && req_v_i[cache_idx(int'(rr_ptr_q) + i)]) begin
                rr_found = 1'b1;
                rr_grant = cache_idx(int'(rr_ptr_q) + i);
            end
        end
    end

    // Grant FSM: IDLE arbitrates, HELD keeps the offer stable until accepted.
    always_comb begin
        state_d     = state_q;
        locked_id_d = locked_id_q;
        grant       = rr_grant;
        tx_v        = 1'b0;
        case (state_q)
            IDLE: begin
                grant = rr_grant;
                tx_v  = !full && rr_found;
                if (tx_v && !tx_yumi_i) begin
                    state_d     = HELD;
                    locked_id_d = rr_grant;
                end
            end
            HELD: begin
                grant = locked_id_q;
                tx_v  = !full && req_v_i[locked_id_q];
                if (tx_v && tx_yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs stay quiet while reset is asserted, even with requests pending.
        if (reset_i) begin
            tx_v = 1'b0;
        end
    end

    // Handshake outputs, response steering and counter/pointer updates.
    always_comb begin
        push = tx_v && tx_yumi_i;
        pop  = axi_bvalid_i && (count_q != '0) && !reset_i;

        req_yumi_o    = '0;
        tx_v_o        = tx_v;
        tx_cache_id_o = '0;
        tx_addr_o     = '0;
        tx_mask_o     = '0;
        if (tx_v) begin
            tx_cache_id_o = grant;
            tx_addr_o     = req_addr_i[int'(grant)*addr_width_p +: addr_width_p];
            tx_mask_o     = req_mask_i[int'(grant)*mask_width_p +: mask_width_p];
        end
        if (push) begin
            req_yumi_o[grant] = 1'b1;
        end

        wr_done_o = '0;
        wr_err_o  = '0;
        if (pop) begin
            wr_done_o[head] = 1'b1;
            wr_err_o[head]  = |axi_bresp_i;
        end

        count_d        = count_q + lg_out_lp'(push) - lg_out_lp'(pop);
        wr_ptr_d       = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d       = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        rr_ptr_d       = push ? cache_idx(int'(grant) + 1) : rr_ptr_q;
        protocol_err_d = protocol_err_q | (axi_bvalid_i && (count_q == '0));

        outstanding_o  = count_q;
        protocol_err_o = protocol_err_q;
    end

    // Control state; reset drops every outstanding write and the lock.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            locked_id_q    <= '0;
            rr_ptr_q       <= '0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            locked_id_q    <= locked_id_d;
            rr_ptr_q       <= rr_ptr_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // Id FIFO storage; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= grant;
        end
    end

endmodule

// File: tb/tb_bsg_cache_to_axi_tx_arbiter.sv
// Directed bench for bsg_cache_to_axi_tx_arbiter with a scoreboard for
// grants and write-done responses plus inline cycle checks.
module tb_bsg_cache_to_axi_tx_arbiter;

    localparam logic [27:0] A0 = 28'hA5A0010;
    localparam logic [27:0] A1 = 28'h5A5F020;
    localparam logic [7:0]  M0 = 8'h0F;
    localparam logic [7:0]  M1 = 8'hC3;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [1:0]  req_v;
    logic [55:0] req_addr;
    logic [15:0] req_mask;
    logic        tx_yumi;
    logic        bvalid;
    logic [1:0]  bresp;

    logic [1:0]  req_yumi;
    logic        tx_v;
    logic [0:0]  tx_cache_id;
    logic [27:0] tx_addr;
    logic [7:0]  tx_mask;
    logic [1:0]  wr_done;
    logic [1:0]  wr_err;
    logic [2:0]  outstanding;
    logic        perr;

    int checks = 0;
    int errors = 0;
    int exp_grant_q[$];
    int exp_done_q[$];
    int mon_g;
    int mon_d;
    int drain_id[4]  = '{1, 0, 1, 0};
    int drain_rsp[4] = '{0, 1, 3, 0};

    bsg_cache_to_axi_tx_arbiter #(
        .num_cache_p(2), .addr_width_p(28), .mask_width_p(8), .max_outstanding_p(4)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v), .req_addr_i(req_addr), .req_mask_i(req_mask),
        .req_yumi_o(req_yumi),
        .tx_v_o(tx_v), .tx_cache_id_o(tx_cache_id), .tx_addr_o(tx_addr), .tx_mask_o(tx_mask),
        .tx_yumi_i(tx_yumi),
        .axi_bvalid_i(bvalid), .axi_bresp_i(bresp),
        .wr_done_o(wr_done), .wr_err_o(wr_err),
        .outstanding_o(outstanding), .protocol_err_o(perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] addr_of(input int id);
        return (id == 0) ? A0 : A1;
    endfunction

    function automatic logic [7:0] mask_of(input int id);
        return (id == 0) ? M0 : M1;
    endfunction

    task automatic drive(input logic [1:0] v, input logic y, input logic b, input logic [1:0] r);
        req_v   = v;
        tx_yumi = y;
        bvalid  = b;
        bresp   = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed request and every write-done pulse pops the scoreboard.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (req_yumi != 2'b00) begin
                if (exp_grant_q.size() == 0) begin
                    chk("unexpected_grant", 64'(req_yumi), 64'd0);
                end else begin
                    mon_g = exp_grant_q.pop_front();
                    chk("grant_yumi", 64'(req_yumi), 64'd1 << mon_g);
                    chk("grant_id", 64'(tx_cache_id), 64'(mon_g));
                    chk("grant_addr", 64'(tx_addr), 64'(addr_of(mon_g)));
                    chk("grant_mask", 64'(tx_mask), 64'(mask_of(mon_g)));
                end
            end
            if (wr_done != 2'b00) begin
                if (exp_done_q.size() == 0) begin
                    chk("unexpected_done", 64'(wr_done), 64'd0);
                end else begin
                    mon_d = exp_done_q.pop_front();
                    chk("done_onehot", 64'(wr_done), 64'd1 << (mon_d / 2));
                    chk("done_err", 64'(wr_err), (mon_d % 2 == 1) ? (64'd1 << (mon_d / 2)) : 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        req_addr = {A1, A0};
        req_mask = {M1, M0};
        reset_i  = 1'b1;
        drive(2'b11, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("rst_tx_v", 64'(tx_v), 64'd0);
        chk("rst_yumi", 64'(req_yumi), 64'd0);
        chk("rst_out", 64'(outstanding), 64'd0);
        chk("rst_perr", 64'(perr), 64'd0);
        chk("rst_addr", 64'(tx_addr), 64'd0);
        next_cycle();
        reset_i = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("idle_tx_v", 64'(tx_v), 64'd0);
        chk("idle_done", 64'(wr_done), 64'd0);
        next_cycle();

        // Single request, accepted immediately.
        exp_grant_q.push_back(0);
        drive(2'b01, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        chk("t1_tx_v", 64'(tx_v), 64'd1);
        chk("t1_out_before", 64'(outstanding), 64'd0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t1_out_after", 64'(outstanding), 64'd1);
        chk("t1_tx_v_off", 64'(tx_v), 64'd0);
        next_cycle();
        exp_done_q.push_back(0 * 2 + 0);
        drive(2'b00, 1'b0, 1'b1, 2'b00);
        @(negedge clk);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t1_drained", 64'(outstanding), 64'd0);
        next_cycle();

        // Fresh reset so arbitration restarts at cache 0.
        reset_i = 1'b1;
        next_cycle();
        reset_i = 1'b0;

        // Both caches streaming with a B response every cycle after the first.
        for (int i = 0; i < 4; i++) begin
            exp_grant_q.push_back(i % 2);
            exp_done_q.push_back((i % 2) * 2);
        end
        for (int c = 0; c < 5; c++) begin
            drive((c < 4) ? 2'b11 : 2'b00, c < 4, c > 0, 2'b00);
            @(negedge clk);
            chk($sformatf("t2_out_c%0d", c), 64'(outstanding), (c == 0) ? 64'd0 : 64'd1);
            next_cycle();
        end
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t2_out_end", 64'(outstanding), 64'd0);
        chk("t2_perr", 64'(perr), 64'd0);
        next_cycle();

        // Lock on cache 1 while cache 0 (higher rr priority) also requests.
        drive(2'b10, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t3_v", 64'(tx_v), 64'd1);
        chk("t3_id", 64'(tx_cache_id), 64'd1);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive(2'b11, 1'b0, 1'b0, 2'b00);
            @(negedge clk);
            chk("t3_hold_id", 64'(tx_cache_id), 64'd1);
            chk("t3_hold_addr", 64'(tx_addr), 64'(A1));
            next_cycle();
        end
        exp_grant_q.push_back(1);
        drive(2'b10, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        chk("t3_final_addr", 64'(tx_addr), 64'(A1));
        next_cycle();
        exp_grant_q.push_back(0);
        drive(2'b01, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        next_cycle();
        exp_done_q.push_back(1 * 2 + 0);
        exp_done_q.push_back(0 * 2 + 0);
        drive(2'b00, 1'b0, 1'b1, 2'b00);
        next_cycle();
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t3_out", 64'(outstanding), 64'd0);
        next_cycle();

        // Fill to the limit, then an error response frees one slot.
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(0);
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 1'b1, 1'b0, 2'b00);
            next_cycle();
        end
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        chk("t4_full_v", 64'(tx_v), 64'd0);
        chk("t4_full_out", 64'(outstanding), 64'd4);
        chk("t4_full_addr", 64'(tx_addr), 64'd0);
        chk("t4_full_id", 64'(tx_cache_id), 64'd0);
        next_cycle();
        exp_done_q.push_back(1 * 2 + 1);
        drive(2'b11, 1'b0, 1'b1, 2'b10);
        @(negedge clk);
        chk("t4_b_v", 64'(tx_v), 64'd0);
        next_cycle();
        drive(2'b11, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t4_reopen_v", 64'(tx_v), 64'd1);
        chk("t4_reopen_id", 64'(tx_cache_id), 64'd1);
        chk("t4_reopen_out", 64'(outstanding), 64'd3);
        next_cycle();
        exp_grant_q.push_back(1);
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        next_cycle();

        // B and a pending request at count==max: no bypass grant.
        exp_done_q.push_back(0 * 2 + 0);
        drive(2'b11, 1'b1, 1'b1, 2'b00);
        @(negedge clk);
        chk("t5_nobypass_v", 64'(tx_v), 64'd0);
        chk("t5_out_full", 64'(outstanding), 64'd4);
        next_cycle();
        exp_grant_q.push_back(0);
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        chk("t5_grant_v", 64'(tx_v), 64'd1);
        chk("t5_out_3", 64'(outstanding), 64'd3);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t5_back4", 64'(outstanding), 64'd4);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            exp_done_q.push_back(drain_id[i] * 2 + ((drain_rsp[i] != 0) ? 1 : 0));
            drive(2'b00, 1'b0, 1'b1, 2'(drain_rsp[i]));
            next_cycle();
        end
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t5_drained", 64'(outstanding), 64'd0);
        chk("t5_perr", 64'(perr), 64'd0);
        next_cycle();

        // Stray B response, then reset in the middle of a held grant.
        drive(2'b00, 1'b0, 1'b1, 2'b00);
        @(negedge clk);
        chk("t6_perr_pre", 64'(perr), 64'd0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t6_perr_set", 64'(perr), 64'd1);
        next_cycle();
        exp_grant_q.push_back(1);
        drive(2'b10, 1'b1, 1'b0, 2'b00);
        @(negedge clk);
        chk("t6_perr_sticky", 64'(perr), 64'd1);
        next_cycle();
        drive(2'b01, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t6_hold_v", 64'(tx_v), 64'd1);
        chk("t6_hold_id", 64'(tx_cache_id), 64'd0);
        chk("t6_hold_out", 64'(outstanding), 64'd1);
        next_cycle();
        #1;
        reset_i = 1'b1;
        #1;
        chk("t6_rst_v", 64'(tx_v), 64'd0);
        chk("t6_rst_yumi", 64'(req_yumi), 64'd0);
        chk("t6_rst_perr", 64'(perr), 64'd0);
        chk("t6_rst_out", 64'(outstanding), 64'd0);
        chk("t6_rst_addr", 64'(tx_addr), 64'd0);
        chk("t6_rst_done", 64'(wr_done), 64'd0);
        next_cycle();
        reset_i = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t6_post_v", 64'(tx_v), 64'd0);
        chk("t6_post_out", 64'(outstanding), 64'd0);
        next_cycle();
        exp_grant_q.push_back(1);
        drive(2'b10, 1'b1, 1'b0, 2'b00);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("t6_final_out", 64'(outstanding), 64'd1);
        next_cycle();

        chk("sb_grant_empty", 64'(exp_grant_q.size()), 64'd0);
        chk("sb_done_empty", 64'(exp_done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
